// File: rtl/bcd_counter_n.sv
// bcd_counter_n: cascaded N-digit BCD up/down counter with synchronous load,
// clear and count enable (priority Load > Clr > Cin). All outputs registered.
// Optional macro BCD_COUNTER_SAT_EN: saturate at all-9s / all-0s instead of
// wrapping; Count then flags each blocked step.
module bcd_counter_n #(
  parameter int DIGITS = 3,
  parameter int W      = 4 * DIGITS
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         Cin,
  input  logic         Up,
  input  logic         Clr,
  input  logic         Load,
  input  logic [W-1:0] Din,
  output logic         Count,
  output logic [W-1:0] q,
  output logic         Err
);

  // True when every nibble of v is a legal BCD digit (0..9).
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // One ripple step across all digits in a single cycle. The returned MSB is
  // the carry/borrow out of the top digit, set only when every digit wrapped,
  // i.e. the count was all 9s (up) or all 0s (down).
  function automatic logic [W:0] bcd_step(input logic [W-1:0] v, input logic up);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (c) begin
        if (up) begin
          if (d == 4'd9) begin
            r[4*k +: 4] = 4'd0;
            c           = 1'b1;
          end else begin
            r[4*k +: 4] = d + 4'd1;
            c           = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*k +: 4] = 4'd9;
            c           = 1'b1;
          end else begin
            r[4*k +: 4] = d - 4'd1;
            c           = 1'b0;
          end
        end
      end else begin
        r[4*k +: 4] = d;
      end
    end
    return {c, r};
  endfunction

  logic [W-1:0] q_r;
  logic         count_r;
  logic         err_r;
  logic [W-1:0] q_nxt_s;
  logic         count_nxt_s;
  logic         err_nxt_s;
  logic [W:0]   step_s;

  // Next-state selection in priority order Load > Clr > Cin > hold.
  always_comb begin
    q_nxt_s     = q_r;
    count_nxt_s = 1'b0;
    err_nxt_s   = 1'b0;
    step_s      = bcd_step(q_r, Up);
    if (Load) begin
      if (bcd_valid(Din)) begin
        q_nxt_s = Din;
      end else begin
        // Reject: keep the count so q never shows a non-BCD nibble.
        err_nxt_s = 1'b1;
      end
    end else if (Clr) begin
      q_nxt_s = {W{1'b0}};
    end else if (Cin) begin
      count_nxt_s = step_s[W];
`ifdef BCD_COUNTER_SAT_EN
      if (step_s[W]) begin
        q_nxt_s = q_r;
      end else begin
        q_nxt_s = step_s[W-1:0];
      end
`else
      q_nxt_s = step_s[W-1:0];
`endif
    end else begin
      q_nxt_s = q_r;
    end
  end

  // Output registers; reset clears them immediately, independent of Clk.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      q_r     <= {W{1'b0}};
      count_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      q_r     <= q_nxt_s;
      count_r <= count_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign q     = q_r;
  assign Count = count_r;
  assign Err   = err_r;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench for bcd_counter_n: directed boundary scenarios followed
// by randomized traffic, checked against a decimal-integer reference model.
module tb_bcd_counter_n;

  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 10 ** DIGITS - 1;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         Cin = 1'b0;
  logic         Up = 1'b0;
  logic         Clr = 1'b0;
  logic         Load = 1'b0;
  logic [W-1:0] Din = '0;
  logic         Count;
  logic [W-1:0] q;
  logic         Err;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: the count as a plain decimal integer.
  int unsigned mval = 0;
  logic        exp_count;
  logic        exp_err;

  bcd_counter_n #(.DIGITS(DIGITS)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Cin(Cin), .Up(Up), .Clr(Clr),
    .Load(Load), .Din(Din), .Count(Count), .q(q), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decimal integer -> packed BCD.
  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    t = v;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Packed BCD -> decimal integer; ok cleared if any nibble exceeds 9.
  function automatic int unsigned from_bcd(input logic [W-1:0] v, output logic ok);
    int unsigned r;
    int unsigned scale;
    r = 0;
    scale = 1;
    ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) ok = 1'b0;
      r = r + scale * int'(v[4*k +: 4]);
      scale = scale * 10;
    end
    return r;
  endfunction

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_next();
    logic        ok;
    int unsigned v;
    exp_count = 1'b0;
    exp_err   = 1'b0;
    if (Load) begin
      v = from_bcd(Din, ok);
      if (ok) mval = v;
      else exp_err = 1'b1;
    end else if (Clr) begin
      mval = 0;
    end else if (Cin) begin
      if (Up) begin
        if (mval == MAXV) begin
          exp_count = 1'b1;
`ifndef BCD_COUNTER_SAT_EN
          mval = 0;
`endif
        end else begin
          mval = mval + 1;
        end
      end else begin
        if (mval == 0) begin
          exp_count = 1'b1;
`ifndef BCD_COUNTER_SAT_EN
          mval = MAXV;
`endif
        end else begin
          mval = mval - 1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs to the model.
  task automatic do_cycle(input logic ld, input logic cl, input logic ci,
                          input logic u, input logic [W-1:0] dn, input string tag);
    Load = ld; Clr = cl; Cin = ci; Up = u; Din = dn;
    model_next();
    @(posedge Clk);
    #1;
    check_val({tag, ".q"},     32'(q),     32'(to_bcd(mval)));
    check_val({tag, ".count"}, 32'(Count), 32'(exp_count));
    check_val({tag, ".err"},   32'(Err),   32'(exp_err));
  endtask

  initial begin
    logic [W-1:0] dn;
    int unsigned  r;

    // Reset state, asserted from time zero.
    #1;
    check_val("rst.q", 32'(q), 32'h0);
    check_val("rst.count", 32'(Count), 32'h0);
    check_val("rst.err", 32'(Err), 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    mval = 0;

    // Idle hold.
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, "idle");

    // Ripple: 099 + 1 -> 100, no Count.
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'h099, "ripple_ld");
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, "ripple");
    check_val("ripple.q_lit", 32'(q), 32'h100);

    // Wrap (or saturate) at 999.
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'h999, "wrap_ld");
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, "wrap");
`ifdef BCD_COUNTER_SAT_EN
    check_val("wrap.q_lit", 32'(q), 32'h999);
`else
    check_val("wrap.q_lit", 32'(q), 32'h000);
`endif
    check_val("wrap.count_lit", 32'(Count), 32'h1);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, "wrap_after");

    // Borrow at 000.
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, "borrow_ld");
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, "borrow");
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, "borrow2");

    // Invalid load leaves q and pulses Err for one cycle.
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'h123, "inv_ld");
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1, 12'h1A5, "inv");
    check_val("inv.q_lit", 32'(q), 32'h123);
    check_val("inv.err_lit", 32'(Err), 32'h1);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, "inv_after");

    // Priority Load > Clr > Cin.
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 12'h456, "prio_ld");
    do_cycle(1'b1, 1'b1, 1'b1, 1'b1, 12'h321, "prio_load");
    check_val("prio_load.q_lit", 32'(q), 32'h321);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 12'h000, "prio_clr");

    // 500 steps from zero, then asynchronous reset between edges.
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 12'h000, "cnt_clr");
    for (int i = 0; i < 500; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, "cnt500");
    check_val("cnt500.q_lit", 32'(q), 32'h500);
    #2;
    Rst_n = 1'b0;
    #1;
    check_val("arst.q", 32'(q), 32'h0);
    check_val("arst.count", 32'(Count), 32'h0);
    check_val("arst.err", 32'(Err), 32'h0);
    #1;
    Rst_n = 1'b1;
    mval = 0;
    for (int i = 0; i < 7; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 12'h000, "post_rst");
    check_val("post_rst.q_lit", 32'(q), 32'h007);

    // Reset held across an edge with Load pending: the load is discarded.
    Load = 1'b1; Din = 12'h777; Cin = 1'b1;
    @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    check_val("rst_load.q", 32'(q), 32'h0);
    Rst_n = 1'b1;
    mval = 0;
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 12'h000, "rst_load_next");

    // Randomized traffic, biased toward the 000/999 boundaries.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) dn = $urandom();
      else if (r == 1) dn = to_bcd($urandom_range(0, 2));
      else if (r == 2) dn = to_bcd(MAXV - $urandom_range(0, 2));
      else dn = to_bcd($urandom_range(0, MAXV));
      do_cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 3) != 0), 1'($urandom()), dn, "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
